// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide sequencer.
package ex_muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Divides carry a 1 in the upper op bit.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_datapath.sv
// Operand capture, radix-2 shift-add multiply / restoring divide step,
// and the final sign fix that commits HI/LO.
module ex_muldiv_datapath
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             EX_rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic               is_div_reg, sign_a_reg, sign_b_reg;
  logic [WIDTH-1:0]   mcand_reg, divisor_reg, quo_reg, rem_reg, hi_reg, lo_reg;
  logic [2*WIDTH-1:0] acc_reg;

  logic               is_signed, sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, rem_shift, rem_trial;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    sign_a    = is_signed & src_a[WIDTH-1];
    sign_b    = is_signed & src_b[WIDTH-1];
    abs_a     = sign_a ? -src_a : src_a;
    abs_b     = sign_b ? -src_b : src_b;
    // Upper half plus multiplicand keeps its carry so the right shift brings it in.
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    rem_trial = rem_shift - {1'b0, divisor_reg};
    prod_fix  = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
    quo_fix   = (sign_a_reg ^ sign_b_reg) ? -quo_reg : quo_reg;
    rem_fix   = sign_a_reg ? -rem_reg : rem_reg;
  end

  always_ff @(posedge clk or negedge EX_rst_n) begin
    if (!EX_rst_n) begin
      is_div_reg  <= 1'b0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      mcand_reg   <= '0;
      divisor_reg <= '0;
      acc_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      if (load) begin
        is_div_reg  <= op_is_div(op);
        sign_a_reg  <= sign_a;
        sign_b_reg  <= sign_b;
        mcand_reg   <= abs_a;
        divisor_reg <= abs_b;
        acc_reg     <= {{WIDTH{1'b0}}, abs_b};
        rem_reg     <= '0;
        quo_reg     <= abs_a;
      end else if (step) begin
        if (is_div_reg) begin
          // A borrow out of the trial subtract means restore the shifted value.
          rem_reg <= rem_trial[WIDTH] ? rem_shift[WIDTH-1:0] : rem_trial[WIDTH-1:0];
          quo_reg <= {quo_reg[WIDTH-2:0], ~rem_trial[WIDTH]};
        end else begin
          acc_reg <= {mul_sum, acc_reg[WIDTH-1:1]};
        end
      end
      if (fix) begin
        hi_reg <= is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_reg <= is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: rtl/ex_muldiv_seq.sv
// Multiply/divide sequencer beside the EX ALU: FSM, iteration counter,
// pipeline stall and done/div-by-zero reporting.
module ex_muldiv_seq
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             EX_rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             dbz_reg, dbz_next;
  logic             load, step, fix;

  always_ff @(posedge clk or negedge EX_rst_n) begin
    if (!EX_rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    dbz_next   = dbz_reg;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !flush) begin
          load       = 1'b1;
          count_next = '0;
          // Zero divisor skips the iterations and leaves HI/LO untouched.
          if (op_is_div(op) && (src_b == '0)) begin
            state_next = DONE;
            dbz_next   = 1'b1;
          end else begin
            state_next = CALC;
            dbz_next   = 1'b0;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          step       = 1'b1;
          count_next = count_reg + 1'b1;
          if (count_reg == LAST) state_next = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          fix        = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // DONE does not stall so the EX instruction retires on the done cycle.
  assign stall       = ((state_reg == IDLE) && start && !flush) ||
                       (state_reg == CALC) || (state_reg == FIX);
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign div_by_zero = (state_reg == DONE) && dbz_reg;

  ex_muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk     (clk),
    .EX_rst_n(EX_rst_n),
    .load    (load),
    .step    (step),
    .fix     (fix),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .hi      (hi),
    .lo      (lo)
  );

endmodule
